// File: rtl/ice40_spi_display_receiver_pkg.sv
// Shared definitions for the display-link SPI receiver: D/C tag values, FIFO entry layout
// and the bit-shift helper used by the byte assembler.
package ice40_spi_display_receiver_pkg;

  localparam logic SPI_DC_CMD  = 1'b0;
  localparam logic SPI_DC_DATA = 1'b1;

  localparam int ENTRY_W = 9;

  // FIFO entry: bit 8 = dc, bits 7:0 = data
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b, input bit lsb_first);
    logic [7:0] r;
    if (lsb_first) begin
      r = {b, sr[7:1]};
    end else begin
      r = {sr[6:0], b};
    end
    return r;
  endfunction

endpackage

// File: rtl/ice40_spi_display_receiver_sync_fifo.sv
// Generic single-clock show-ahead FIFO with wrap-bit pointers. A push while full is only
// accepted when a pop in the same cycle frees the slot; otherwise push_drop flags the loss.
module ice40_spi_display_receiver_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             push_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  // Status decode and show-ahead head.
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop_ok    = pop && !empty;
    push_ok   = push && (!full || pop_ok);
    push_drop = push && full && !pop_ok;
    head      = mem[rd_ptr[AW-1:0]];
  end

  // Storage and pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ice40_spi_display_receiver.sv
// Display-side SPI target: oversamples sck/cs/si/dc, assembles D/C-tagged bytes into a FIFO.
// Define SPI_RX_STATS_EN to add byte_count / drop_count / frame_count statistics outputs.
module ice40_spi_display_receiver
  import ice40_spi_display_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LSB_FIRST   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        cs,
  input  logic        si,
  input  logic        dc,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_dc,
  output logic        cs_active,
  output logic        overrun,
`ifdef SPI_RX_STATS_EN
  output logic [15:0] byte_count,
  output logic [7:0]  drop_count,
  output logic [7:0]  frame_count,
`endif
  output logic        frame_err
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] si_sync;
  logic [SYNC_STAGES-1:0] dc_sync;

  logic       sck_s;
  logic       cs_s;
  logic       si_s;
  logic       dc_s;
  logic       sck_prev;
  logic       sck_rise;
  logic       cs_rise;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] next_shift;
  logic       byte_done;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       push_drop;
  logic       fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  rx_entry_t  head_entry;

  // Bring the asynchronous bus into the clk domain; idle is sck=0, cs=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      si_sync  <= '0;
      dc_sync  <= '0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      si_sync  <= {si_sync[SYNC_STAGES-2:0], si};
      dc_sync  <= {dc_sync[SYNC_STAGES-2:0], dc};
    end
  end

  // Edge detection; cs_active doubles as the previous-cycle cs level.
  always_comb begin
    sck_s      = sck_sync[SYNC_STAGES-1];
    cs_s       = cs_sync[SYNC_STAGES-1];
    si_s       = si_sync[SYNC_STAGES-1];
    dc_s       = dc_sync[SYNC_STAGES-1];
    sck_rise   = sck_s && !sck_prev && cs_active;
    cs_rise    = cs_s && cs_active;
    next_shift = shift_in(shift_reg, si_s, (LSB_FIRST != 0));
  end

  // Shifter, bit counter and byte hand-off; a completed byte is pushed the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_prev  <= 1'b0;
      cs_active <= 1'b0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      byte_done <= 1'b0;
      byte_data <= 8'd0;
      byte_dc   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sck_prev  <= sck_s;
      cs_active <= !cs_s;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= push_drop;
      if (cs_rise) begin
        frame_err <= (bit_cnt != 3'd0);
        bit_cnt   <= 3'd0;
        shift_reg <= 8'd0;
      end else if (sck_rise) begin
        shift_reg <= next_shift;
        if (bit_cnt == 3'd7) begin
          bit_cnt   <= 3'd0;
          byte_done <= 1'b1;
          byte_data <= next_shift;
          byte_dc   <= dc_s ? SPI_DC_DATA : SPI_DC_CMD;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  ice40_spi_display_receiver_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (byte_done),
    .push_data ({byte_dc, byte_data}),
    .pop       (rx_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .push_drop (push_drop)
  );

  // Consumer-side view of the FIFO head.
  always_comb begin
    head_entry = fifo_head;
    rx_valid   = !fifo_empty;
    rx_data    = head_entry.data;
    rx_dc      = head_entry.dc;
  end

`ifdef SPI_RX_STATS_EN
  logic cs_fall;

  // A cs assert edge is cs low now while the previous cycle was idle.
  always_comb begin
    cs_fall = !cs_s && !cs_active;
  end

  // Link statistics: wrapping byte and frame counts, saturating drop count.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_count  <= 16'd0;
      drop_count  <= 8'd0;
      frame_count <= 8'd0;
    end else begin
      if (byte_done && !push_drop) begin
        byte_count <= byte_count + 16'd1;
      end
      if (push_drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
      if (cs_fall) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end
`endif

endmodule
